// File: rtl/div3_pkg.sv
// Shared types and constants for the sequential divide-by-3 block.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Remainder register only ever holds one of these three codes.
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

endpackage

// File: rtl/div3_rem_step.sv
// One restoring-division step by 3: shift one dividend bit into the remainder.
module div3_rem_step
    import div3_pkg::*;
(
    input  logic [1:0] rem,
    input  logic       b,
    output logic [1:0] rem_next,
    output logic       qbit
);

    logic [2:0] t;

    // t = 2*rem + b never exceeds 5 for legal remainders, so one subtract suffices.
    always_comb begin
        t        = {rem, b};
        qbit     = (t >= 3'd3);
        rem_next = R0;
        if (qbit) begin
            rem_next = 2'(t - 3'd3);
        end else begin
            rem_next = t[1:0];
        end
    end

endmodule

// File: rtl/div3_seq.sv
// Bit-serial unsigned divide-by-3, MSB first, with valid/ready handshakes on both sides.
module div3_seq
    import div3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quot,
    output logic [1:0]        out_rem,
    output logic              out_divisible
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [1:0]        rem;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] quot;
    logic [1:0]        rem_next;
    logic              qbit;

    div3_rem_step u_step (
        .rem      (rem),
        .b        (data[DATA_W-1]),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // The dividend register has no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && !rst && in_valid) begin
            data <= in_data;
        end else if (state == BUSY) begin
            data <= {data[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= R0;
            cnt       <= '0;
            quot      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= R0;
                        cnt      <= CNT_LOAD;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    rem  <= rem_next;
                    quot <= {quot[DATA_W-2:0], qbit};
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Returning to IDLE here keeps accepts off the handshake edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_quot      = quot;
    assign out_rem       = rem;
    assign out_divisible = (rem == R0);

endmodule

// File: tb/tb_div3_seq.sv
// Directed and randomized checks of div3_seq against plain x/3 and x%3 arithmetic.
module tb_div3_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
    logic [1:0]   out_rem;
    logic         out_divisible;

    int passed = 0;
    int total  = 0;

    div3_seq #(.DATA_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quot      (out_quot),
        .out_rem       (out_rem),
        .out_divisible (out_divisible)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One complete transaction: accept x, hold the result for `hold` cycles, then hand it off.
    task automatic do_op(input int x, input int hold, input bit poke);
        int n;
        int q;
        int r;
        q = x / 3;
        r = x % 3;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = W'(x);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            out_ready = 1'($urandom);
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("latency", 32'(n), 32'(W));
        chk("quot", 32'(out_quot), 32'(q));
        chk("rem", 32'(out_rem), 32'(r));
        chk("divisible", 32'(out_divisible), 32'(r == 0));
        chk("rem_legal", 32'(out_rem != 2'd3), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 2) begin
                in_valid = 1'b1;
                in_data  = W'(x + 1);
            end
            tick();
            in_valid = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_quot", 32'(out_quot), 32'(q));
            chk("hold_rem", 32'(out_rem), 32'(r));
        end
        // Offer a new dividend on the handshake edge: it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        in_data   = W'($urandom);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("after_hs_valid", 32'(out_valid), 32'd0);
        chk("after_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(out_quot), 32'd0);
        chk("rst_rem", 32'(out_rem), 32'd0);
        chk("rst_divisible", 32'(out_divisible), 32'd1);

        // Idle with in_valid low: nothing happens.
        tick();
        chk("idle_hold", 32'(in_ready), 32'd1);

        do_op(0, 0, 1'b0);
        do_op(255, 1, 1'b0);
        do_op(200, 0, 1'b0);
        do_op(7, 2, 1'b0);
        do_op(100, 5, 1'b1);

        // Abort in the 4th BUSY cycle.
        in_valid = 1'b1;
        in_data  = W'(150);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quot", 32'(out_quot), 32'd0);
        chk("abort_rem", 32'(out_rem), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("abort_no_result", 32'(seen), 32'd0);
        end
        out_ready = 1'b0;

        for (int x = 0; x < 256; x++) begin
            do_op(x, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
